// File: rtl/writeback_unit.sv
// Writeback stage: merges load responses and ALU results into one registered
// register-file write port, with an in-order ALU buffer and pending-rd flags.
module writeback_unit #(
  parameter int ALU_FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  input  logic [4:0]  rs1_q,
  input  logic [4:0]  rs2_q,
  output logic        busy_rs1,
  output logic        busy_rs2
);
  localparam int PW = $clog2(ALU_FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  wb_req_t                   fifo_q [ALU_FIFO_DEPTH];
  logic [ALU_FIFO_DEPTH-1:0] ent_vld_q, ent_vld_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      wb_valid_q, wb_valid_d;
  logic [4:0]                wb_rd_q, wb_rd_d;
  logic [31:0]               wb_data_q, wb_data_d;

  logic        accept, ld_claim, fifo_empty, pop, direct, push;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;

  always_comb begin
    ld_byte = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_funct3)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'd0, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {16'd0, ld_half};
      default: ld_fmt = ld_rdata;
    endcase
  end

  // Full blocks acceptance even when a pop happens this cycle, keeping ready off the pop path.
  assign alu_ready  = rst && (cnt_q != CW'(ALU_FIFO_DEPTH));
  assign accept     = alu_valid && alu_ready;
  assign ld_claim   = ld_valid && (ld_rd != 5'd0);
  assign fifo_empty = (cnt_q == '0);
  assign pop        = !ld_claim && !fifo_empty;
  assign direct     = !ld_claim && fifo_empty && accept && (alu_rd != 5'd0);
  assign push       = accept && (alu_rd != 5'd0) && !direct;

  always_comb begin
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    if (ld_claim) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = ld_rd;
      wb_data_d  = ld_fmt;
    end else if (pop) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = fifo_q[rd_ptr_q].rd;
      wb_data_d  = fifo_q[rd_ptr_q].data;
    end else if (direct) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = alu_rd;
      wb_data_d  = alu_data;
    end
  end

  always_comb begin
    ent_vld_d = ent_vld_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    if (pop) begin
      ent_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d            = rd_ptr_q + PW'(1);
    end
    if (push) begin
      ent_vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d            = wr_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ent_vld_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      ent_vld_q  <= ent_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Entry storage needs no reset; ent_vld_q qualifies it.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{rd: alu_rd, data: alu_data};
  end

  function automatic logic pending(input logic [4:0] rs);
    logic hit;
    hit = wb_valid_q && (wb_rd_q == rs);
    for (int i = 0; i < ALU_FIFO_DEPTH; i++)
      if (ent_vld_q[i] && (fifo_q[i].rd == rs)) hit = 1'b1;
    return hit && (rs != 5'd0);
  endfunction

  assign busy_rs1 = pending(rs1_q);
  assign busy_rs2 = pending(rs2_q);

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: expected writes (with the cycle they must
// appear) are queued by the stimulus and matched by a negedge monitor.
module tb_writeback_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rs1_q, rs2_q;
  logic        busy_rs1, busy_rs2;

  writeback_unit #(.ALU_FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo),
    .ld_rdata(ld_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1_q(rs1_q), .rs2_q(rs2_q), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Expect a write of rd/data to be visible `dly` edges after the current drive point.
  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] data, input int dly);
    exp_t e;
    e.rd = rd; e.data = data; e.cyc = cyc + dly;
    sb.push_back(e);
  endtask

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ld(input logic v, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] off, input logic [31:0] d);
    ld_valid = v; ld_rd = rd; ld_funct3 = f3; ld_addr_lo = off; ld_rdata = d;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v; alu_rd = rd; alu_data = d;
  endtask

  always @(negedge clk) begin
    if (wb_valid) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL wb_unexpected: got rd=%0d data=%h at cyc %0d want no write", wb_rd, wb_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (wb_rd === e.rd && wb_data === e.data && cyc == e.cyc) passed++;
        else $display("FAIL wb_write: got rd=%0d data=%h cyc=%0d want rd=%0d data=%h cyc=%0d",
                      wb_rd, wb_data, cyc, e.rd, e.data, e.cyc);
      end
    end
  end

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] exp;
  } ldvec_t;

  ldvec_t lv[7];

  initial begin
    lv[0] = '{3'b000, 2'd0, 32'hFFFF_FF81};
    lv[1] = '{3'b100, 2'd3, 32'h0000_0080};
    lv[2] = '{3'b001, 2'd2, 32'hFFFF_80F0};
    lv[3] = '{3'b101, 2'd0, 32'h0000_7F81};
    lv[4] = '{3'b010, 2'd0, 32'h80F0_7F81};
    lv[5] = '{3'b001, 2'd3, 32'hFFFF_80F0};
    lv[6] = '{3'b011, 2'd1, 32'h80F0_7F81};

    rst = 1'b0; rs1_q = 5'd0; rs2_q = 5'd0;
    drive_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    drive_alu(1'b1, 5'd1, 32'h55);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    cyc_start();
    rst = 1'b1;
    drive_alu(1'b0, 5'd0, 32'd0);
    #1;
    chk("release_alu_ready", {31'd0, alu_ready}, 32'd1);

    // load extension, back to back
    foreach (lv[i]) begin
      cyc_start();
      drive_ld(1'b1, 5'd5, lv[i].f3, lv[i].off, 32'h80F0_7F81);
      expect_wb(5'd5, lv[i].exp, 1);
    end
    cyc_start();
    drive_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);

    // collision: load wins the port, ALU result queued
    cyc_start();
    drive_ld(1'b1, 5'd3, 3'b010, 2'd0, 32'h11);
    drive_alu(1'b1, 5'd4, 32'h22);
    chk("coll_alu_ready", {31'd0, alu_ready}, 32'd1);
    expect_wb(5'd3, 32'h11, 1);
    expect_wb(5'd4, 32'h22, 2);
    cyc_start();
    drive_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    drive_alu(1'b0, 5'd0, 32'd0);
    rs1_q = 5'd4; rs2_q = 5'd3;
    @(negedge clk);
    chk("coll_busy_rs1_fifo", {31'd0, busy_rs1}, 32'd1);
    chk("coll_busy_rs2_wb", {31'd0, busy_rs2}, 32'd1);
    repeat (2) cyc_start();
    chk("coll_busy_rs1_clear", {31'd0, busy_rs1}, 32'd0);
    rs1_q = 5'd0; rs2_q = 5'd0;

    // FIFO full: 4 loads, ALU offers rd 6,7,8
    cyc_start();
    drive_ld(1'b1, 5'd10, 3'b010, 2'd0, 32'hA0);
    drive_alu(1'b1, 5'd6, 32'h66);
    expect_wb(5'd10, 32'hA0, 1);
    cyc_start();
    drive_ld(1'b1, 5'd11, 3'b010, 2'd0, 32'hA1);
    drive_alu(1'b1, 5'd7, 32'h77);
    expect_wb(5'd11, 32'hA1, 1);
    cyc_start();
    drive_ld(1'b1, 5'd12, 3'b010, 2'd0, 32'hA2);
    drive_alu(1'b1, 5'd8, 32'h88);
    chk("full_ready_low", {31'd0, alu_ready}, 32'd0);
    expect_wb(5'd12, 32'hA2, 1);
    cyc_start();
    drive_ld(1'b1, 5'd13, 3'b010, 2'd0, 32'hA3);
    expect_wb(5'd13, 32'hA3, 1);
    cyc_start();
    drive_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    chk("full_ready_low_at_pop", {31'd0, alu_ready}, 32'd0);
    expect_wb(5'd6, 32'h66, 1);
    cyc_start();
    chk("full_ready_after_pop", {31'd0, alu_ready}, 32'd1);
    expect_wb(5'd7, 32'h77, 1);
    expect_wb(5'd8, 32'h88, 2);
    cyc_start();
    drive_alu(1'b0, 5'd0, 32'd0);
    repeat (2) cyc_start();

    // x0 suppression
    drive_alu(1'b1, 5'd0, 32'hDEAD);
    chk("x0_alu_ready", {31'd0, alu_ready}, 32'd1);
    cyc_start();
    drive_alu(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("x0_no_write", {31'd0, wb_valid}, 32'd0);
    cyc_start();
    drive_ld(1'b1, 5'd14, 3'b010, 2'd0, 32'hE0);
    drive_alu(1'b1, 5'd9, 32'h99);
    expect_wb(5'd14, 32'hE0, 1);
    cyc_start();
    drive_ld(1'b1, 5'd0, 3'b010, 2'd0, 32'hBAD);
    drive_alu(1'b0, 5'd0, 32'd0);
    expect_wb(5'd9, 32'h99, 1);
    cyc_start();
    drive_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    repeat (2) cyc_start();

    // mid-operation reset with two queued entries
    drive_ld(1'b1, 5'd15, 3'b010, 2'd0, 32'hF5);
    drive_alu(1'b1, 5'd16, 32'h16);
    expect_wb(5'd15, 32'hF5, 1);
    cyc_start();
    drive_ld(1'b1, 5'd17, 3'b010, 2'd0, 32'hF7);
    drive_alu(1'b1, 5'd18, 32'h18);
    expect_wb(5'd17, 32'hF7, 1);
    cyc_start();
    drive_ld(1'b0, 5'd0, 3'd0, 2'd0, 32'd0);
    drive_alu(1'b0, 5'd0, 32'd0);
    rst = 1'b0;
    cyc_start();
    rst = 1'b1;
    rs1_q = 5'd16; rs2_q = 5'd18;
    #1;
    chk("mrst_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("mrst_wb_data", wb_data, 32'd0);
    chk("mrst_busy_rs1", {31'd0, busy_rs1}, 32'd0);
    chk("mrst_busy_rs2", {31'd0, busy_rs2}, 32'd0);
    repeat (6) cyc_start();

    chk("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
